// File: rtl/pixel_serializer.sv
// Frame-scoped serializer: unpacks IN_WIDTH-bit pixel words into OUT_PIX-pixel beats
// through a 2-word buffer, adding start-of-frame (tuser) and end-of-line (tlast) sideband.
module pixel_serializer #(
  parameter int IN_WIDTH  = 256,
  parameter int PIX_WIDTH = 8,
  parameter int OUT_PIX   = 1,
  parameter int IN_ROWS   = 8,
  parameter int IN_COLS   = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ap_start,
  output logic                             ap_done,
  output logic                             ap_idle,
  output logic                             ap_ready,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [IN_WIDTH-1:0]              s_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [OUT_PIX*PIX_WIDTH-1:0]     m_axis_tdata,
  output logic                             m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic [$clog2(IN_COLS)-1:0]       cnt_col,
  output logic [$clog2(IN_ROWS)-1:0]       cnt_row
);

  localparam int PPW = IN_WIDTH / PIX_WIDTH;
  localparam int BPW = PPW / OUT_PIX;
  localparam int WPF = IN_ROWS * IN_COLS / PPW;
  localparam int OW  = OUT_PIX * PIX_WIDTH;
  localparam int CW  = $clog2(IN_COLS);
  localparam int RW  = $clog2(IN_ROWS);
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW  = $clog2(WPF + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [1:0][IN_WIDTH-1:0]   mem_q, mem_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 count_q, count_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [AW-1:0]              words_q, words_d;
  logic [CW-1:0]              cnt_col_q, cnt_col_d;
  logic [RW-1:0]              cnt_row_q, cnt_row_d;

  logic push, pop, word_done, row_end, frame_end;

  // Input acceptance depends only on registered state, so no ready path runs input-to-output.
  assign s_axis_tready = (state_q == S_RUN) && (count_q != 2'd2) && (words_q != AW'(WPF));
  assign m_axis_tvalid = (state_q == S_RUN) && (count_q != 2'd0);
  assign m_axis_tdata  = mem_q[rd_ptr_q][beat_q*OW +: OW];
  assign m_axis_tuser  = (state_q == S_RUN) && (cnt_row_q == '0) && (cnt_col_q == '0);
  assign m_axis_tlast  = (state_q == S_RUN) && row_end;
  assign ap_done       = (state_q == S_DONE);
  assign ap_idle       = (state_q == S_IDLE);
  assign ap_ready      = (state_q == S_IDLE);
  assign cnt_col       = cnt_col_q;
  assign cnt_row       = cnt_row_q;

  always_comb begin
    push      = s_axis_tvalid && s_axis_tready;
    pop       = m_axis_tvalid && m_axis_tready;
    word_done = (beat_q == BW'(BPW - 1));
    row_end   = (cnt_col_q == CW'(IN_COLS - OUT_PIX));
    frame_end = row_end && (cnt_row_q == RW'(IN_ROWS - 1));

    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    beat_d    = beat_q;
    words_d   = words_q;
    cnt_col_d = cnt_col_q;
    cnt_row_d = cnt_row_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d   = S_RUN;
          wr_ptr_d  = 1'b0;
          rd_ptr_d  = 1'b0;
          count_d   = 2'd0;
          beat_d    = '0;
          words_d   = '0;
          cnt_col_d = '0;
          cnt_row_d = '0;
        end
      end
      S_RUN: begin
        if (push) begin
          mem_d[wr_ptr_q] = s_axis_tdata;
          wr_ptr_d        = ~wr_ptr_q;
          words_d         = words_q + AW'(1);
        end
        if (pop) begin
          if (word_done) begin
            beat_d   = '0;
            rd_ptr_d = ~rd_ptr_q;
          end else begin
            beat_d = beat_q + BW'(1);
          end
          if (row_end) begin
            cnt_col_d = '0;
            cnt_row_d = frame_end ? '0 : cnt_row_q + RW'(1);
          end else begin
            cnt_col_d = cnt_col_q + CW'(OUT_PIX);
          end
          if (frame_end) state_d = S_DONE;
        end
        // Simultaneous push and head pop leaves occupancy unchanged.
        count_d = count_q + {1'b0, push} - {1'b0, pop && word_done};
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      beat_q    <= '0;
      words_q   <= '0;
      cnt_col_q <= '0;
      cnt_row_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      words_q   <= words_d;
      cnt_col_q <= cnt_col_d;
      cnt_row_q <= cnt_row_d;
    end
  end

  // Word storage carries no control meaning, so it stays out of the reset domain.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer: three geometries share stimulus; a pixel-array model
// predicts every beat, sideband, counter and handshake availability.
module tb_pixel_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         ap_start = 1'b0;
  logic         s_tvalid = 1'b0;
  logic [255:0] s_tdata = '0;
  logic         m_tready = 1'b0;
  int           sel = 0;

  logic         a_done, a_idle, a_ready, a_str, a_mv, a_user, a_last;
  logic [7:0]   a_data;
  logic [5:0]   a_col;
  logic [2:0]   a_row;
  logic         b_done, b_idle, b_ready, b_str, b_mv, b_user, b_last;
  logic [63:0]  b_data;
  logic [5:0]   b_col;
  logic [2:0]   b_row;
  logic         c_done, c_idle, c_ready, c_str, c_mv, c_user, c_last;
  logic [255:0] c_data;
  logic [5:0]   c_col;
  logic [2:0]   c_row;

  logic         o_done, o_idle, o_ready, o_str, o_mv, o_user, o_last;
  logic [255:0] o_data;
  logic [5:0]   o_col;
  logic [2:0]   o_row;

  pixel_serializer #(.IN_WIDTH(256), .PIX_WIDTH(8), .OUT_PIX(1), .IN_ROWS(8), .IN_COLS(64)) u_a (
    .clk(clk), .reset(reset), .ap_start(ap_start && sel == 0), .ap_done(a_done), .ap_idle(a_idle),
    .ap_ready(a_ready), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_str), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(a_mv), .m_axis_tready(m_tready), .m_axis_tdata(a_data), .m_axis_tuser(a_user),
    .m_axis_tlast(a_last), .cnt_col(a_col), .cnt_row(a_row));

  pixel_serializer #(.IN_WIDTH(256), .PIX_WIDTH(16), .OUT_PIX(4), .IN_ROWS(8), .IN_COLS(64)) u_b (
    .clk(clk), .reset(reset), .ap_start(ap_start && sel == 1), .ap_done(b_done), .ap_idle(b_idle),
    .ap_ready(b_ready), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_str), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(b_mv), .m_axis_tready(m_tready), .m_axis_tdata(b_data), .m_axis_tuser(b_user),
    .m_axis_tlast(b_last), .cnt_col(b_col), .cnt_row(b_row));

  pixel_serializer #(.IN_WIDTH(256), .PIX_WIDTH(8), .OUT_PIX(32), .IN_ROWS(8), .IN_COLS(64)) u_c (
    .clk(clk), .reset(reset), .ap_start(ap_start && sel == 2), .ap_done(c_done), .ap_idle(c_idle),
    .ap_ready(c_ready), .s_axis_tvalid(s_tvalid), .s_axis_tready(c_str), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(c_mv), .m_axis_tready(m_tready), .m_axis_tdata(c_data), .m_axis_tuser(c_user),
    .m_axis_tlast(c_last), .cnt_col(c_col), .cnt_row(c_row));

  always_comb begin
    {o_done, o_idle, o_ready, o_str, o_mv, o_user, o_last} = {a_done, a_idle, a_ready, a_str, a_mv, a_user, a_last};
    o_data = 256'(a_data); o_col = a_col; o_row = a_row;
    if (sel == 1) begin
      {o_done, o_idle, o_ready, o_str, o_mv, o_user, o_last} = {b_done, b_idle, b_ready, b_str, b_mv, b_user, b_last};
      o_data = 256'(b_data); o_col = b_col; o_row = b_row;
    end else if (sel == 2) begin
      {o_done, o_idle, o_ready, o_str, o_mv, o_user, o_last} = {c_done, c_idle, c_ready, c_str, c_mv, c_user, c_last};
      o_data = c_data; o_col = c_col; o_row = c_row;
    end
  end

  int errors = 0;
  int checks = 0;

  // Frame model: 512 pixels in raster order, geometry per selected instance.
  int pix [512];
  int pw, op, ppw, bpw, wpf, nbeats;

  task automatic set_cfg(input int s, input bit random_pix);
    sel    = s;
    pw     = (s == 1) ? 16 : 8;
    op     = (s == 0) ? 1 : (s == 1) ? 4 : 32;
    ppw    = 256 / pw;
    bpw    = ppw / op;
    wpf    = 512 / ppw;
    nbeats = 512 / op;
    for (int i = 0; i < 512; i++) pix[i] = random_pix ? int'($urandom & 32'hffff) : i;
  endtask

  function automatic logic [255:0] pmask();
    logic [255:0] one = 256'd1;
    return (one << pw) - one;
  endfunction

  function automatic logic [255:0] word_of(input int w);
    logic [255:0] r = '0;
    if (w < wpf)
      for (int k = 0; k < ppw; k++) r |= (256'(pix[w*ppw+k]) & pmask()) << (k * pw);
    return r;
  endfunction

  function automatic logic [255:0] beat_of(input int b);
    logic [255:0] r = '0;
    for (int j = 0; j < op; j++) r |= (256'(pix[b*op+j]) & pmask()) << (j * pw);
    return r;
  endfunction

  // Drives one frame from ap_start and checks every cycle until the cycle after ap_done,
  // or stops right after beat count reaches abort_at.
  task automatic run_frame(input int vpct, input int rmode, input int abort_at, input int mid_start_at,
                           output int first_hs, output int last_hs, output int nwords);
    int wi = 0, bi = 0, cyc = 0, nwc;
    bit hold = 0, prev_stall = 0, finished = 0, exp_tr, exp_mv, exp_done;
    logic [255:0] pdata = '0;
    logic puser = 0, plast = 0;
    first_hs = -1; last_hs = -1;
    @(negedge clk);
    s_tvalid = 0; m_tready = 0; ap_start = 1;
    #1;
    checks++;
    if (o_idle !== 1'b1 || o_ready !== 1'b1)
      begin errors++; $display("FAIL idle_before_start: idle=%b ready=%b want 1 1", o_idle, o_ready); end
    @(negedge clk);
    ap_start = 0;
    while (!finished) begin
      if (!hold) begin
        s_tvalid = (wi < wpf) && ($urandom_range(99) < vpct);
        s_tdata  = word_of(wi);
      end
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_tready = 1'($urandom_range(1));
      endcase
      ap_start = (cyc == mid_start_at);
      #1;
      nwc      = wi - bi / bpw;
      exp_tr   = (nwc < 2) && (wi < wpf);
      exp_mv   = (nwc > 0);
      exp_done = (last_hs >= 0) && (cyc == last_hs + 1);
      checks++;
      if (o_str !== exp_tr)
        begin errors++; $display("FAIL s_tready cyc=%0d: got %b want %b", cyc, o_str, exp_tr); end
      checks++;
      if (o_mv !== exp_mv)
        begin errors++; $display("FAIL m_tvalid cyc=%0d: got %b want %b", cyc, o_mv, exp_mv); end
      checks++;
      if (o_done !== exp_done)
        begin errors++; $display("FAIL ap_done cyc=%0d: got %b want %b", cyc, o_done, exp_done); end
      if (prev_stall) begin
        checks++;
        if (o_data !== pdata || o_user !== puser || o_last !== plast)
          begin errors++; $display("FAIL stall_hold cyc=%0d: got %0h want %0h", cyc, o_data, pdata); end
      end
      if (o_mv === 1'b1 && m_tready) begin
        checks++;
        if (o_data !== beat_of(bi))
          begin errors++; $display("FAIL tdata beat=%0d: got %0h want %0h", bi, o_data, beat_of(bi)); end
        checks++;
        if (o_user !== (bi == 0) || o_last !== (((bi * op) % 64) == 64 - op))
          begin errors++; $display("FAIL sideband beat=%0d: got user=%b last=%b want %b %b", bi, o_user, o_last,
                                   bi == 0, ((bi * op) % 64) == 64 - op); end
        checks++;
        if (o_col !== 6'((bi * op) % 64) || o_row !== 3'((bi * op) / 64))
          begin errors++; $display("FAIL counters beat=%0d: got col=%0d row=%0d want %0d %0d", bi, o_col, o_row,
                                   (bi * op) % 64, (bi * op) / 64); end
        if (first_hs < 0) first_hs = cyc;
        bi++;
        if (bi == nbeats) last_hs = cyc;
      end
      prev_stall = (o_mv === 1'b1) && !m_tready;
      pdata = o_data; puser = o_user; plast = o_last;
      hold = s_tvalid && (o_str !== 1'b1);
      if (s_tvalid && o_str === 1'b1) wi++;
      if (exp_done) finished = 1;
      if (abort_at >= 0 && bi == abort_at) finished = 1;
      cyc++;
      if (cyc > 5000) begin errors++; $display("FAIL timeout: beats=%0d want %0d", bi, nbeats); finished = 1; end
      @(negedge clk);
    end
    ap_start = 0; s_tvalid = 0; m_tready = 0;
    nwords = wi;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({o_mv, o_str, o_done, o_user, o_last, o_idle, o_ready} !== 7'b0000011 || o_col !== 6'd0 || o_row !== 3'd0)
        begin errors++; $display("FAIL reset_state inst=%0d: got %b col=%0d row=%0d want 0000011 0 0", s,
                                 {o_mv, o_str, o_done, o_user, o_last, o_idle, o_ready}, o_col, o_row); end
    end
  endtask

  task automatic test_default_stream;
    int f, l, w;
    set_cfg(0, 0);
    run_frame(100, 0, -1, -1, f, l, w);
    checks++;
    if (f !== 1 || l - f !== 511)
      begin errors++; $display("FAIL default_rate: got first=%0d span=%0d want 1 511", f, l - f); end
    checks++;
    if (w !== 16) begin errors++; $display("FAIL default_words: got %0d want 16", w); end
  endtask

  task automatic test_wide_pixels;
    int f, l, w;
    set_cfg(1, 0);
    run_frame(100, 0, -1, -1, f, l, w);
    checks++;
    if (f !== 1 || l - f !== 127)
      begin errors++; $display("FAIL wide_rate: got first=%0d span=%0d want 1 127", f, l - f); end
  endtask

  task automatic test_backpressure;
    int f, l, w;
    set_cfg(0, 1);
    run_frame(100, 1, -1, -1, f, l, w);
    checks++;
    if (w !== 16) begin errors++; $display("FAIL bp_words: got %0d want 16", w); end
  endtask

  task automatic test_bpw1;
    int f, l, w;
    set_cfg(2, 1);
    run_frame(100, 0, -1, -1, f, l, w);
    checks++;
    if (f !== 1 || l - f !== 15)
      begin errors++; $display("FAIL bpw1_rate: got first=%0d span=%0d want 1 15", f, l - f); end
  endtask

  task automatic test_reset_midframe;
    int f, l, w;
    set_cfg(0, 1);
    run_frame(100, 0, 101, -1, f, l, w);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if (o_mv !== 1'b0 || o_str !== 1'b0 || o_idle !== 1'b1 || o_col !== 6'd0 || o_row !== 3'd0 || o_done !== 1'b0)
      begin errors++; $display("FAIL midframe_reset: got mv=%b str=%b idle=%b col=%0d row=%0d done=%b want 0 0 1 0 0 0",
                               o_mv, o_str, o_idle, o_col, o_row, o_done); end
    @(negedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0 || o_idle !== 1'b1)
      begin errors++; $display("FAIL midframe_no_done: got done=%b idle=%b want 0 1", o_done, o_idle); end
    run_frame(60, 2, -1, -1, f, l, w);
  endtask

  task automatic test_start_ignored_and_overrun;
    int f, l, w;
    set_cfg(0, 1);
    run_frame(80, 2, -1, 50, f, l, w);
    s_tvalid = 1; s_tdata = '1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (o_str !== 1'b0 || o_done !== 1'b0 || o_idle !== 1'b1)
        begin errors++; $display("FAIL overrun cyc=%0d: got str=%b done=%b idle=%b want 0 0 1", i, o_str, o_done, o_idle); end
      @(negedge clk);
    end
    s_tvalid = 0;
    set_cfg(1, 1);
    run_frame(70, 2, -1, 20, f, l, w);
  endtask

  task automatic test_random;
    int f, l, w;
    for (int n = 0; n < 3; n++) begin
      set_cfg(int'($urandom_range(2)), 1);
      run_frame(int'($urandom_range(90, 30)), 2, -1, -1, f, l, w);
      checks++;
      if (w !== wpf) begin errors++; $display("FAIL random_words: got %0d want %0d", w, wpf); end
    end
  endtask

  initial begin
    test_reset;
    test_default_stream;
    test_wide_pixels;
    test_backpressure;
    test_bpw1;
    test_reset_midframe;
    test_start_ignored_and_overrun;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
